// File: rtl/window_pkg.sv
// Shared types for the window monitor: qualified state and raw sample class.
package window_pkg;

  typedef enum logic [1:0] {
    W_OK   = 2'd0,
    W_HIGH = 2'd1,
    W_LOW  = 2'd2
  } window_state_t;

  // A raw class uses the same encoding, so it can be compared against the state directly.
  typedef window_state_t window_class_t;

endpackage

// File: rtl/window_classify.sv
// Combinational classification of one sample against the window limits.
// WINDOW_HYST_EN adds a return band when leaving HIGH or LOW for OK.
module window_classify
  import window_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] top_limit,
  input  logic [WIDTH-1:0] bottom_limit,
  input  logic [WIDTH-1:0] hysteresis,
  input  window_state_t    state,
  output window_class_t    cls
);

`ifdef WINDOW_HYST_EN
  function automatic logic [WIDTH-1:0] clamp_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[WIDTH] ? '0 : d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] clamp_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] hi_exit;
  logic [WIDTH-1:0] lo_exit;

  assign hi_exit = clamp_sub(top_limit, hysteresis);
  assign lo_exit = clamp_add(bottom_limit, hysteresis);
`else
  logic unused_hyst;
  assign unused_hyst = ^{hysteresis, state};
`endif

  // Entry thresholds always win; the band only holds an existing HIGH/LOW.
  always_comb begin
    cls = W_OK;
    if (value > top_limit) begin
      cls = W_HIGH;
    end else if (value < bottom_limit) begin
      cls = W_LOW;
    end
`ifdef WINDOW_HYST_EN
    else if ((state == W_HIGH) && (value > hi_exit)) begin
      cls = W_HIGH;
    end else if ((state == W_LOW) && (value < lo_exit)) begin
      cls = W_LOW;
    end
`endif
  end

endmodule

// File: rtl/window_monitor.sv
// Debounced window comparator with sticky alarms and a saturating excursion count.
// Optional return-band hysteresis is enabled with WINDOW_HYST_EN.
module window_monitor
  import window_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEBOUNCE  = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Sample_Valid,
  input  logic [WIDTH-1:0]     Value,
  input  logic [WIDTH-1:0]     Top_Limit,
  input  logic [WIDTH-1:0]     Bottom_Limit,
  input  logic [WIDTH-1:0]     Hysteresis,
  input  logic                 Clear_Alarm,
  output logic                 Too_High,
  output logic                 OK,
  output logic                 Too_Low,
  output logic                 Alarm_High,
  output logic                 Alarm_Low,
  output logic [CNT_WIDTH-1:0] Excursions,
  output logic                 Limit_Error
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  window_state_t        state;
  window_state_t        cand;
  logic [DB_W-1:0]      cnt;
  logic                 lim_err;
  logic                 alarm_h;
  logic                 alarm_l;
  logic [CNT_WIDTH-1:0] exc;

  window_class_t        cls;
  window_state_t        nxt_state;
  window_state_t        nxt_cand;
  logic [DB_W-1:0]      nxt_cnt;
  logic [DB_W-1:0]      run_len;
  logic                 entry_high;
  logic                 entry_low;

  window_classify #(
    .WIDTH(WIDTH)
  ) u_classify (
    .value       (Value),
    .top_limit   (Top_Limit),
    .bottom_limit(Bottom_Limit),
    .hysteresis  (Hysteresis),
    .state       (state),
    .cls         (cls)
  );

  // A run of DEBOUNCE equal, non-state classes commits on the edge of the last one.
  always_comb begin
    nxt_state = state;
    nxt_cand  = cand;
    nxt_cnt   = cnt;
    run_len   = '0;
    if (lim_err) begin
      nxt_cnt = '0;
    end else if (Sample_Valid) begin
      if (cls == state) begin
        nxt_cnt = '0;
      end else begin
        if (cls == cand) begin
          run_len = cnt + 1'b1;
        end else begin
          nxt_cand = cls;
          run_len  = DB_W'(1);
        end
        if (run_len == DB_TARGET) begin
          nxt_state = cls;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = run_len;
        end
      end
    end
  end

  assign entry_high = (nxt_state == W_HIGH) && (state != W_HIGH);
  assign entry_low  = (nxt_state == W_LOW)  && (state != W_LOW);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= W_OK;
      cand    <= W_OK;
      cnt     <= '0;
      lim_err <= 1'b0;
      alarm_h <= 1'b0;
      alarm_l <= 1'b0;
      exc     <= '0;
    end else begin
      state   <= nxt_state;
      cand    <= nxt_cand;
      cnt     <= nxt_cnt;
      lim_err <= (Bottom_Limit > Top_Limit);
      // A clear on the same edge as an entry still records that entry.
      if (Clear_Alarm) begin
        alarm_h <= entry_high;
        alarm_l <= entry_low;
        exc     <= (entry_high || entry_low) ? CNT_WIDTH'(1) : '0;
      end else begin
        alarm_h <= alarm_h | entry_high;
        alarm_l <= alarm_l | entry_low;
        if (entry_high || entry_low) begin
          exc <= sat_inc(exc);
        end
      end
    end
  end

  assign Too_High    = (state == W_HIGH);
  assign OK          = (state == W_OK);
  assign Too_Low     = (state == W_LOW);
  assign Alarm_High  = alarm_h;
  assign Alarm_Low   = alarm_l;
  assign Excursions  = exc;
  assign Limit_Error = lim_err;

endmodule

// File: tb/tb_window_monitor.sv
// Scoreboard bench for window_monitor: directed test-plan sequences then random traffic.
module tb_window_monitor;

  localparam int WIDTH     = 4;
  localparam int DEBOUNCE  = 3;
  localparam int CNT_WIDTH = 8;
  localparam int VMAX      = (1 << WIDTH) - 1;
  localparam int CMAX      = (1 << CNT_WIDTH) - 1;
`ifdef WINDOW_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  logic                 Clock = 1'b0;
  logic                 Reset = 1'b1;
  logic                 Sample_Valid = 1'b0;
  logic [WIDTH-1:0]     Value = '0;
  logic [WIDTH-1:0]     Top_Limit = WIDTH'(11);
  logic [WIDTH-1:0]     Bottom_Limit = WIDTH'(4);
  logic [WIDTH-1:0]     Hysteresis = '0;
  logic                 Clear_Alarm = 1'b0;
  logic                 Too_High;
  logic                 OK;
  logic                 Too_Low;
  logic                 Alarm_High;
  logic                 Alarm_Low;
  logic [CNT_WIDTH-1:0] Excursions;
  logic                 Limit_Error;

  always #5 Clock = ~Clock;

  window_monitor #(
    .WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Sample_Valid(Sample_Valid), .Value(Value),
    .Top_Limit(Top_Limit), .Bottom_Limit(Bottom_Limit), .Hysteresis(Hysteresis),
    .Clear_Alarm(Clear_Alarm), .Too_High(Too_High), .OK(OK), .Too_Low(Too_Low),
    .Alarm_High(Alarm_High), .Alarm_Low(Alarm_Low), .Excursions(Excursions),
    .Limit_Error(Limit_Error)
  );

  typedef struct {
    int st;
    int ah;
    int al;
    int exc;
    int lerr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0=OK 1=HIGH 2=LOW
  int   m_state = 0;
  int   m_ah = 0, m_al = 0, m_exc = 0, m_lerr = 0;
  int   hist[$];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int classify(input int v, input int top, input int bot,
                                  input int hy, input int st);
    int hi_exit, lo_exit;
    hi_exit = (top - hy < 0) ? 0 : top - hy;
    lo_exit = (bot + hy > VMAX) ? VMAX : bot + hy;
    if (v > top) return 1;
    if (v < bot) return 2;
    if (HYST_EN && st == 1 && v > hi_exit) return 1;
    if (HYST_EN && st == 2 && v < lo_exit) return 2;
    return 0;
  endfunction

  task automatic step(input bit rst, input bit vld, input int v, input int top,
                      input int bot, input int hy, input bit clr);
    int ns;
    bit same;
    exp_t e;
    Reset        = rst;
    Sample_Valid = vld;
    Value        = WIDTH'(v);
    Top_Limit    = WIDTH'(top);
    Bottom_Limit = WIDTH'(bot);
    Hysteresis   = WIDTH'(hy);
    Clear_Alarm  = clr;
    if (rst) begin
      m_state = 0; m_ah = 0; m_al = 0; m_exc = 0; m_lerr = 0;
      hist.delete();
    end else begin
      ns = m_state;
      if (m_lerr != 0) begin
        hist.delete();
      end else if (vld) begin
        hist.push_back(classify(v, top, bot, hy, m_state));
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (hist.size() == DEBOUNCE) begin
          same = 1'b1;
          foreach (hist[k]) if (hist[k] != hist[0]) same = 1'b0;
          if (same && hist[0] != m_state) begin
            ns = hist[0];
            hist.delete();
          end
        end
      end
      if (clr) begin
        m_ah  = (ns != m_state && ns == 1) ? 1 : 0;
        m_al  = (ns != m_state && ns == 2) ? 1 : 0;
        m_exc = (ns != m_state && ns != 0) ? 1 : 0;
      end else if (ns != m_state && ns != 0) begin
        if (ns == 1) m_ah = 1; else m_al = 1;
        if (m_exc < CMAX) m_exc++;
      end
      m_state = ns;
      m_lerr  = (bot > top) ? 1 : 0;
    end
    e.st = m_state; e.ah = m_ah; e.al = m_al; e.exc = m_exc; e.lerr = m_lerr;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic samples(input int n, input int v, input int hy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, v, 11, 4, hy, 1'b0);
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("too_high", int'(Too_High), (e.st == 1) ? 1 : 0);
      check("ok", int'(OK), (e.st == 0) ? 1 : 0);
      check("too_low", int'(Too_Low), (e.st == 2) ? 1 : 0);
      check("alarm_high", int'(Alarm_High), e.ah);
      check("alarm_low", int'(Alarm_Low), e.al);
      check("excursions", int'(Excursions), e.exc);
      check("limit_error", int'(Limit_Error), e.lerr);
    end
  end

  initial begin
    int top, bot;
    step(1'b1, 1'b0, 0, 11, 4, 0, 1'b0);
    step(1'b1, 1'b1, 12, 11, 4, 0, 1'b1);
    samples(5, 7, 0);
    check("dir_idle_ok", int'(OK), 1);
    check("dir_idle_exc", int'(Excursions), 0);

    samples(2, 12, 0);
    samples(1, 7, 0);
    check("dir_short_run_ok", int'(OK), 1);
    samples(3, 12, 0);
    check("dir_high", int'(Too_High), 1);
    check("dir_alarm_high", int'(Alarm_High), 1);
    check("dir_exc1", int'(Excursions), 1);

    samples(3, 7, 0);
    samples(2, 12, 0); samples(1, 7, 0); samples(2, 12, 0);
    check("dir_broken_run", int'(OK), 1);
    samples(1, 12, 0);
    check("dir_broken_then_high", int'(Too_High), 1);
    samples(3, 2, 0);
    check("dir_direct_low", int'(Too_Low), 1);
    check("dir_alarm_low", int'(Alarm_Low), 1);

    samples(3, 12, 0);
    samples(2, 2, 0);
    step(1'b0, 1'b1, 2, 11, 4, 0, 1'b1);
    check("dir_clr_set_low", int'(Alarm_Low), 1);
    check("dir_clr_high", int'(Alarm_High), 0);
    check("dir_clr_exc", int'(Excursions), 1);

    for (int i = 0; i < 130; i++) begin
      samples(3, 12, 0);
      samples(3, 2, 0);
    end
    check("dir_exc_sat", int'(Excursions), CMAX);

    samples(3, 7, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 15, 3, 9, 0, 1'b0);
    check("dir_lerr", int'(Limit_Error), 1);
    check("dir_lerr_ok", int'(OK), 1);
    samples(1, 7, 0);
    check("dir_lerr_clear", int'(Limit_Error), 0);

    samples(3, 12, 2);
    samples(3, 10, 2);
    check("dir_hyst_band", int'(Too_High), HYST_EN ? 1 : 0);
    samples(3, 9, 2);
    check("dir_hyst_exit", int'(OK), 1);

    samples(2, 12, 0);
    step(1'b1, 1'b1, 12, 11, 4, 0, 1'b1);
    samples(1, 12, 0);
    check("dir_reset_midrun", int'(OK), 1);

    top = 11; bot = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        top = $urandom_range(0, VMAX);
        bot = $urandom_range(0, VMAX);
      end else if ($urandom_range(0, 19) == 0) begin
        top = 11; bot = 4;
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, VMAX), top, bot, $urandom_range(0, 5),
           $urandom_range(0, 15) == 0);
    end

    @(negedge Clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
